// File: rtl/sd_spi_responder_pkg.sv
// Shared definitions for the SPI-mode SD card responder: command indices,
// R1 response bits, data token and the command/response state machine encoding.
package sd_spi_responder_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;

    typedef enum logic [3:0] {
        ST_WAIT_CMD,
        ST_CMD_RX,
        ST_NCR,
        ST_RESP,
        ST_R7_TAIL,
        ST_NAC,
        ST_TOKEN,
        ST_DATA,
        ST_CRC
    } sd_state_t;

    // R1 for a received command. CMD0 always reports idle because it puts the
    // card back into the idle state. While idle, only the initialisation
    // commands are accepted; everything else (and any unknown index) flags
    // an illegal command.
    function automatic logic [7:0] r1_value(input logic [5:0] idx, input logic idle);
        logic legal;
        logic init_cmd;
        logic idle_eff;
        logic err;
        legal    = (idx == CMD0)  || (idx == CMD8)  || (idx == CMD16) ||
                   (idx == CMD17) || (idx == CMD41) || (idx == CMD55);
        init_cmd = (idx == CMD0)  || (idx == CMD8)  || (idx == CMD41) || (idx == CMD55);
        idle_eff = (idx == CMD0) ? 1'b1 : idle;
        err      = !legal || (idle_eff && !init_cmd);
        return (err ? R1_ILLEGAL : 8'h00) | (idle_eff ? R1_IDLE : 8'h00);
    endfunction

endpackage

// File: rtl/sd_spi_responder_shifter.sv
// SPI mode-0 target bit engine: brings the host's SD_CLK/SD_CS/SD_MOSI into
// the iCLK domain, shifts received bits in on rising SD_CLK and transmit bits
// out on falling SD_CLK, and flags each completed byte.
module spi_target_shifter (
    input  logic       iCLK,
    input  logic       Reset_n,
    input  logic       SD_CLK,
    input  logic       SD_CS,
    input  logic       SD_MOSI,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       cs_idle,
    output logic       miso
);

    logic [1:0] clk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       clk_d;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic [2:0] bit_cnt;

    assign sclk_rise = clk_sync[1] & ~clk_d;
    assign sclk_fall = ~clk_sync[1] & clk_d;
    assign cs_idle   = cs_sync[1];

    // Two-flop synchronisers for the host signals plus SD_CLK edge history.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            clk_d     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], SD_CLK};
            cs_sync   <= {cs_sync[0], SD_CS};
            mosi_sync <= {mosi_sync[0], SD_MOSI};
            clk_d     <= clk_sync[1];
        end
    end

    // Receive path: sample MOSI on rising SD_CLK, strobe byte_done on the 8th bit.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_sr     <= 8'h00;
            rx_byte   <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_idle) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_sr   <= {rx_sr[6:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {rx_sr[6:0], mosi_sync[1]};
                end
            end
        end
    end

    // Transmit path: a loaded byte has its MSB driven on the next falling edge.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_sr <= 8'hFF;
            miso  <= 1'b1;
        end else if (cs_idle) begin
            tx_sr <= 8'hFF;
            miso  <= 1'b1;
        end else if (tx_load) begin
            tx_sr <= tx_byte;
        end else if (sclk_fall) begin
            miso  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b1};
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// Stand-in SPI-mode SD card: decodes 6-byte command frames, answers with
// R1/R7 and serves single-block reads from a byte-wide memory port.
module sd_spi_responder
    import sd_spi_responder_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int NAC_BYTES   = 2,
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_W      = 32
) (
    input  logic              iCLK,
    input  logic              Reset_n,
    input  logic              SD_CLK,
    input  logic              SD_CS,
    input  logic              SD_MOSI,
    output logic              SD_MISO,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemRead,
    input  logic [7:0]        iMemData,
    output logic              oCmdValid,
    output logic [5:0]        oCmdIndex,
    output logic [31:0]       oCmdArg,
    output logic              oIdle
);

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        cs_idle;
    logic [7:0]  tx_byte;

    sd_state_t   state;
    sd_state_t   state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [31:0] arg_sr;
    logic        app_flag;
    logic        rd_pend;
    logic [7:0]  data_buf;

    logic        cmd_start;
    logic        arg_shift;
    logic        cmd_done;
    logic        set_idle;
    logic        clr_idle;
    logic        enter_resp;
    logic        enter_token;
    logic        rd_first;
    logic        rd_next;

    spi_target_shifter u_shifter (
        .iCLK      (iCLK),
        .Reset_n   (Reset_n),
        .SD_CLK    (SD_CLK),
        .SD_CS     (SD_CS),
        .SD_MOSI   (SD_MOSI),
        .tx_load   (byte_done),
        .tx_byte   (tx_byte),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .cs_idle   (cs_idle),
        .miso      (SD_MISO)
    );

    // Next state and the byte to transmit next, decided at each byte boundary.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tx_byte     = FILL_BYTE;
        cmd_start   = 1'b0;
        arg_shift   = 1'b0;
        cmd_done    = 1'b0;
        set_idle    = 1'b0;
        clr_idle    = 1'b0;
        enter_resp  = 1'b0;
        enter_token = 1'b0;
        rd_first    = 1'b0;
        rd_next     = 1'b0;
        if (byte_done) begin
            case (state)
                ST_WAIT_CMD: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        cmd_start = 1'b1;
                        state_n   = ST_CMD_RX;
                        cnt_n     = 16'd0;
                    end
                end
                ST_CMD_RX: begin
                    if (cnt == 16'd4) begin
                        // Fifth byte is the CRC, which is not checked.
                        cmd_done = 1'b1;
                        cnt_n    = 16'd0;
                        if (NCR_BYTES == 0) enter_resp = 1'b1;
                        else                state_n    = ST_NCR;
                    end else begin
                        arg_shift = 1'b1;
                        cnt_n     = cnt + 16'd1;
                    end
                end
                ST_NCR: begin
                    if (cnt == 16'(NCR_BYTES - 1)) enter_resp = 1'b1;
                    else                           cnt_n      = cnt + 16'd1;
                end
                ST_RESP: begin
                    // ACMD41 takes the card out of idle once its R1 has gone out.
                    clr_idle = (oCmdIndex == CMD41) && app_flag;
                    cnt_n    = 16'd0;
                    if (oCmdIndex == CMD8) begin
                        state_n = ST_R7_TAIL;
                        tx_byte = 8'h00;
                    end else if (oCmdIndex == CMD17) begin
                        if (NAC_BYTES == 0) enter_token = 1'b1;
                        else                state_n     = ST_NAC;
                    end else begin
                        state_n = ST_WAIT_CMD;
                    end
                end
                ST_R7_TAIL: begin
                    cnt_n = cnt + 16'd1;
                    case (cnt[1:0])
                        2'd0:    tx_byte = 8'h00;
                        2'd1:    tx_byte = {4'h0, oCmdArg[11:8]};
                        2'd2:    tx_byte = oCmdArg[7:0];
                        default: state_n = ST_WAIT_CMD;
                    endcase
                end
                ST_NAC: begin
                    if (cnt == 16'(NAC_BYTES - 1)) enter_token = 1'b1;
                    else                           cnt_n       = cnt + 16'd1;
                end
                ST_TOKEN: begin
                    state_n = ST_DATA;
                    cnt_n   = 16'd0;
                    tx_byte = data_buf;
                    rd_next = (BLOCK_BYTES > 1);
                end
                ST_DATA: begin
                    if (cnt == 16'(BLOCK_BYTES - 1)) begin
                        state_n = ST_CRC;
                        cnt_n   = 16'd0;
                    end else begin
                        // Prefetch the byte after the one now being loaded, unless
                        // the loaded byte is the last of the block.
                        cnt_n   = cnt + 16'd1;
                        tx_byte = data_buf;
                        rd_next = (32'(cnt) + 32'd2) < 32'(BLOCK_BYTES);
                    end
                end
                ST_CRC: begin
                    if (cnt == 16'd1) state_n = ST_WAIT_CMD;
                    else              cnt_n   = cnt + 16'd1;
                end
                default: state_n = ST_WAIT_CMD;
            endcase
            if (enter_resp) begin
                state_n  = ST_RESP;
                tx_byte  = r1_value(oCmdIndex, oIdle);
                set_idle = (oCmdIndex == CMD0);
            end
            if (enter_token) begin
                state_n  = ST_TOKEN;
                tx_byte  = DATA_TOKEN;
                rd_first = 1'b1;
            end
        end
    end

    // State register; deselecting the card abandons any transfer.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_WAIT_CMD;
            cnt   <= 16'd0;
        end else if (cs_idle) begin
            state <= ST_WAIT_CMD;
            cnt   <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Command capture, idle flag and CMD55 application-command flag.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            oCmdValid <= 1'b0;
            oCmdIndex <= 6'd0;
            oCmdArg   <= 32'd0;
            arg_sr    <= 32'd0;
            app_flag  <= 1'b0;
            oIdle     <= 1'b1;
        end else begin
            oCmdValid <= 1'b0;
            if (!cs_idle) begin
                if (cmd_start) oCmdIndex <= rx_byte[5:0];
                if (arg_shift) arg_sr <= {arg_sr[23:0], rx_byte};
                if (cmd_done) begin
                    oCmdValid <= 1'b1;
                    oCmdArg   <= arg_sr;
                    if (oCmdIndex == CMD55)      app_flag <= 1'b1;
                    else if (oCmdIndex != CMD41) app_flag <= 1'b0;
                end
                if (set_idle)      oIdle <= 1'b1;
                else if (clr_idle) oIdle <= 1'b0;
            end
        end
    end

    // Block-read prefetch: one strobe per byte, data captured the cycle after.
    always_ff @(posedge iCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            oMemRead <= 1'b0;
            oMemAddr <= '0;
            rd_pend  <= 1'b0;
            data_buf <= 8'h00;
        end else begin
            oMemRead <= 1'b0;
            rd_pend  <= oMemRead;
            if (rd_pend) data_buf <= iMemData;
            if (!cs_idle) begin
                if (rd_first) begin
                    oMemRead <= 1'b1;
                    oMemAddr <= ADDR_W'(oCmdArg);
                end else if (rd_next) begin
                    oMemRead <= 1'b1;
                    oMemAddr <= oMemAddr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed and randomised SPI host stimulus for sd_spi_responder, checked
// against a byte-level model of the card's command/response behaviour.
module tb_sd_spi_responder;

    localparam int NCR  = 1;
    localparam int NAC  = 2;
    localparam int BLK  = 512;
    localparam int HALF = 60;

    logic        iCLK = 1'b0;
    logic        Reset_n;
    logic        SD_CLK;
    logic        SD_CS;
    logic        SD_MOSI;
    logic        SD_MISO;
    logic [31:0] oMemAddr;
    logic        oMemRead;
    logic [7:0]  iMemData;
    logic        oCmdValid;
    logic [5:0]  oCmdIndex;
    logic [31:0] oCmdArg;
    logic        oIdle;

    int          total = 0;
    int          bad = 0;
    int          cmd_pulses = 0;
    int          exp_pulses = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  mem_key = 8'h00;
    logic        m_idle = 1'b1;
    logic        m_app = 1'b0;

    sd_spi_responder dut (
        .iCLK      (iCLK),
        .Reset_n   (Reset_n),
        .SD_CLK    (SD_CLK),
        .SD_CS     (SD_CS),
        .SD_MOSI   (SD_MOSI),
        .SD_MISO   (SD_MISO),
        .oMemAddr  (oMemAddr),
        .oMemRead  (oMemRead),
        .iMemData  (iMemData),
        .oCmdValid (oCmdValid),
        .oCmdIndex (oCmdIndex),
        .oCmdArg   (oCmdArg),
        .oIdle     (oIdle)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ mem_key;
    endfunction

    // Memory model and monitors for read strobes and command pulses.
    initial begin
        iMemData = 8'h00;
        forever begin
            @(negedge iCLK);
            if (oMemRead === 1'b1) begin
                rd_q.push_back(oMemAddr);
                iMemData = mem_byte(oMemAddr);
            end
            if (oCmdValid === 1'b1) cmd_pulses++;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            SD_MOSI = tx[i];
            #HALF;
            SD_CLK = 1'b1;
            rx[i] = SD_MISO;
            #HALF;
            SD_CLK = 1'b0;
        end
    endtask

    // Expected MISO bytes following a command frame, plus card state update.
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        bit legal;
        bit init_cmd;
        bit err;
        exp_q.delete();
        legal    = idx inside {6'd0, 6'd8, 6'd16, 6'd17, 6'd41, 6'd55};
        init_cmd = idx inside {6'd0, 6'd8, 6'd41, 6'd55};
        if (idx == 6'd0) m_idle = 1'b1;
        err = !legal || (m_idle && !init_cmd);
        for (int i = 0; i < NCR; i++) exp_q.push_back(8'hFF);
        exp_q.push_back({5'd0, err, 1'b0, m_idle});
        if (idx == 6'd8) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back({4'h0, arg[11:8]});
            exp_q.push_back(arg[7:0]);
        end
        if (idx == 6'd17) begin
            for (int i = 0; i < NAC; i++) exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int i = 0; i < BLK; i++) exp_q.push_back(mem_byte(arg + 32'(i)));
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
        end
        if (idx == 6'd41 && m_app) m_idle = 1'b0;
        if (idx == 6'd55)      m_app = 1'b1;
        else if (idx != 6'd41) m_app = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int limit, input string tag);
        logic [7:0] frame [6];
        logic [7:0] rx;
        logic [7:0] all_rx;
        int         n;
        frame[0] = {2'b01, idx};
        frame[1] = arg[31:24];
        frame[2] = arg[23:16];
        frame[3] = arg[15:8];
        frame[4] = arg[7:0];
        frame[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : (8'($urandom) | 8'h01);
        model_cmd(idx, arg);
        exp_pulses++;
        all_rx = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            xfer(frame[i], rx);
            all_rx = all_rx & rx;
        end
        check({tag, "_cmd_miso"}, 32'(all_rx), 32'hFF);
        n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, rx);
            check($sformatf("%s_byte%0d", tag, i), 32'(rx), 32'(exp_q[i]));
        end
        check({tag, "_pulses"}, 32'(cmd_pulses), 32'(exp_pulses));
        check({tag, "_index"}, 32'(oCmdIndex), 32'(idx));
        check({tag, "_arg"}, oCmdArg, arg);
        check({tag, "_idle"}, 32'(oIdle), 32'(m_idle));
    endtask

    initial begin
        logic [31:0] arg;
        logic [5:0]  idx;
        int          errs;
        int          nrd;
        SD_CLK  = 1'b0;
        SD_CS   = 1'b1;
        SD_MOSI = 1'b1;
        Reset_n = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset_miso", 32'(SD_MISO), 32'd1);
        check("reset_memread", 32'(oMemRead), 32'd0);
        check("reset_memaddr", oMemAddr, 32'd0);
        check("reset_cmdvalid", 32'(oCmdValid), 32'd0);
        check("reset_cmdindex", 32'(oCmdIndex), 32'd0);
        check("reset_cmdarg", oCmdArg, 32'd0);
        check("reset_idle", 32'(oIdle), 32'd1);
        #24;
        Reset_n = 1'b1;
        SD_CS   = 1'b0;

        run_cmd(6'd0, 32'h0000_0000, -1, "cmd0");
        run_cmd(6'd8, 32'h0000_01AA, -1, "cmd8");
        run_cmd(6'd8, $urandom, -1, "cmd8_rnd");
        run_cmd(6'd55, 32'h0, -1, "cmd55_a");
        run_cmd(6'd41, 32'h4000_0000, -1, "acmd41_a");
        run_cmd(6'd55, 32'h0, -1, "cmd55_b");
        run_cmd(6'd41, 32'h4000_0000, -1, "acmd41_b");

        for (int k = 0; k < 4; k++) begin
            idx = 6'($urandom_range(0, 63));
            if (idx == 6'd17) idx = 6'd16;
            run_cmd(idx, $urandom, -1, $sformatf("rnd%0d", k));
        end
        run_cmd(6'd55, 32'h0, -1, "cmd55_c");
        run_cmd(6'd41, 32'h4000_0000, -1, "acmd41_c");

        // Full block read with random address and memory pattern.
        mem_key = 8'($urandom);
        arg     = $urandom;
        rd_q.delete();
        run_cmd(6'd17, arg, -1, "blk");
        check("blk_reads", 32'(rd_q.size()), 32'(BLK));
        errs = 0;
        foreach (rd_q[i]) if (rd_q[i] !== arg + 32'(i)) errs++;
        check("blk_read_addr", 32'(errs), 32'd0);

        // Deselect after 10 data bytes, with the address wrapping past 2^32.
        arg = 32'hFFFF_FFFA;
        rd_q.delete();
        run_cmd(6'd17, arg, NCR + 1 + NAC + 1 + 10, "abort");
        SD_CS = 1'b1;
        #100;
        check("abort_miso", 32'(SD_MISO), 32'd1);
        nrd = rd_q.size();
        check("abort_reads", 32'(nrd), 32'd12);
        #2000;
        check("abort_no_more_reads", 32'(rd_q.size()), 32'd12);
        errs = 0;
        foreach (rd_q[i]) if (rd_q[i] !== arg + 32'(i)) errs++;
        check("abort_read_addr", 32'(errs), 32'd0);
        SD_CS = 1'b0;
        run_cmd(6'd0, 32'h0, -1, "cmd0_after_abort");
        run_cmd(6'd55, 32'h0, -1, "cmd55_d");
        run_cmd(6'd41, 32'h4000_0000, -1, "acmd41_d");

        // Asynchronous reset in the middle of a block.
        run_cmd(6'd17, $urandom | 32'h0000_0100, NCR + 1 + NAC + 1 + 3, "rst_blk");
        #30;
        Reset_n = 1'b0;
        #1;
        check("midrst_miso", 32'(SD_MISO), 32'd1);
        check("midrst_memread", 32'(oMemRead), 32'd0);
        check("midrst_memaddr", oMemAddr, 32'd0);
        check("midrst_cmdvalid", 32'(oCmdValid), 32'd0);
        check("midrst_cmdindex", 32'(oCmdIndex), 32'd0);
        check("midrst_cmdarg", oCmdArg, 32'd0);
        check("midrst_idle", 32'(oIdle), 32'd1);
        #19;
        Reset_n = 1'b1;
        #40;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD-card target: the card end of the SD SPI link driven by the processor's SD host controller.
- Receives 6-byte commands on SD_MOSI and returns R1/R7 responses on SD_MISO.
- Serves CMD17 single-block reads from an attached byte-wide memory port.
- Used as a bench/FPGA stand-in card so host-side SD code runs without a physical card.

Parameters:
NCR_BYTES, 1, 0xFF filler bytes between end of command and first response byte
NAC_BYTES, 2, 0xFF filler bytes between R1 and data token 0xFE on CMD17
BLOCK_BYTES, 512, data bytes per CMD17 block
ADDR_W, 32, memory address width

Ports:
iCLK  input  1  system clock; must be at least 8x the SD_CLK frequency
Reset_n  input  1  asynchronous active-low reset
SD_CLK  input  1  SPI clock from host, mode 0
SD_CS  input  1  chip select from host, active low
SD_MOSI  input  1  host-to-card serial data
SD_MISO  output  1  card-to-host serial data
oMemAddr  output  ADDR_W  byte address for block data
oMemRead  output  1  one-iCLK read strobe
iMemData  input  8  read data, valid the iCLK after oMemRead
oCmdValid  output  1  one-iCLK pulse when a full command frame is received
oCmdIndex  output  6  index of last command
oCmdArg  output  32  argument of last command
oIdle  output  1  card idle-state flag (R1 bit 0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- SD_CLK, SD_CS and SD_MOSI pass through 2-FF synchronisers into iCLK; edges are detected on the synchronised SD_CLK.
- Rising SD_CLK: sample MOSI into the rx shift register and increment the 3-bit bit counter.
- Falling SD_CLK: shift out the next tx bit.
- Byte boundary = 8th rising edge. A new tx byte is loaded at the boundary; its MSB is driven after the following falling edge.
- SD_CS high: SD_MISO=1, bit counter=0, FSM forced to WAIT_CMD. Any transfer in progress is aborted with no memory strobe afterwards. oIdle is preserved.
- Reset values: SD_MISO=1, oMemRead=0, oMemAddr=0, oCmdValid=0, oCmdIndex=0, oCmdArg=0, oIdle=1, FSM=WAIT_CMD.
- FSM states (transitions occur only at byte boundaries):
  - WAIT_CMD: tx=0xFF. A byte with bits[7:6]=01 stores the index and goes to CMD_RX; any other byte stays.
  - CMD_RX: collect 4 argument bytes plus the CRC byte (CRC ignored). Pulse oCmdValid, latch oCmdArg, go to NCR.
  - NCR: send NCR_BYTES x 0xFF, then RESP.
  - RESP: send R1 = {7'b0, oIdle} for legal commands; R1 = 0x04 | oIdle for any other index.
  - R7_TAIL: CMD8 only. Sends 0x00, 0x00, arg[11:8], arg[7:0] after R1.
  - NAC: send NAC_BYTES x 0xFF.
  - TOKEN: send 0xFE.
  - DATA: send BLOCK_BYTES bytes.
  - CRC: send 0xFF, 0xFF, then return to WAIT_CMD.
- Command decode:
  - CMD0 sets oIdle=1; response 0x01.
  - CMD8 -> R7_TAIL.
  - CMD16 -> R1 only.
  - CMD55 sets app flag. ACMD41 (CMD41 with app flag set) clears oIdle after its R1, so the first ACMD41 returns 0x01 and the second returns 0x00. Any non-41 command clears the app flag.
  - CMD17 -> RESP, NAC, TOKEN, DATA, CRC.
  - Any command other than CMD0 while in RESP with oIdle=1, except CMD8/55/41, returns 0x05.
- Data prefetch:
  - Entering TOKEN issues oMemRead with oMemAddr=arg. The captured byte is loaded at the next boundary.
  - Each DATA byte load issues the next read at arg+i+1 (address wraps mod 2^ADDR_W).
  - No read is issued after byte BLOCK_BYTES-1.
- MOSI content is ignored outside WAIT_CMD/CMD_RX.

Decomposition:
- Shared package: SD command index constants (CMD0/8/16/17/41/55), R1 bit masks, token 0xFE, FSM state enum.
- One sub-module, spi_target_shifter: synchronisers, edge detect, rx/tx shift registers, bit counter, byte_done strobe, tx_load input.
- The FSM stays in the top level.

Test Plan:
- CS low, send 40 00 00 00 00 95 then 0xFF bytes -> 1 filler 0xFF, then R1=0x01; oCmdValid pulses once with index 0.
- Send 48 00 00 01 AA 87 -> R1 0x01 then 00 00 01 AA.
- Send CMD55 + ACMD41 twice -> R1 0x01 then 0x00; oIdle falls after the second ACMD41.
- CMD17 arg 0x00000100, memory returns addr[7:0] -> R1 0x00, 2x FF, FE, bytes 00..FF twice, FF FF; exactly 512 oMemRead pulses at 0x100..0x2FF.
- Raise SD_CS after byte 10 of a data block -> MISO=1 immediately, no further oMemRead; next CMD0 answers normally.
- Assert Reset_n low mid-block -> all outputs return to reset values asynchronously; oIdle=1.
